ddc_slv_regbuf: RTL and testbench

//  Byte-addressed DDC/EDID register buffer sitting directly downstream of the ddc_slv
//  I2C slave. Consumes its byte events (i2c_start/i2c_read/i2c_strobe/i2c_mst_data/
//  i2c_spc_stop) and returns read data on i2c_slv_data. Holds the offset pointer
//  (write-offset, then sequential read/write with wrap) and a host-side programming port.

---
 rtl/ddc_slv_pkg.sv | 15 +
 rtl/ddc_slv_ram.sv | 28 ++
 rtl/ddc_slv_regbuf.sv | 128 ++++++++++++
 tb/tb_ddc_slv_regbuf.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddc_slv_pkg.sv
// DDC register buffer shared types.
// State encoding and default parameters.
package ddc_slv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OFFSET,
    ST_WDATA,
    ST_RDATA
  } ddc_st_t;

  localparam int         DDC_AW_DEF  = 8;
  localparam logic [7:0] DDC_RD_IDLE = 8'hFF;

endpackage

// File: rtl/ddc_slv_ram.sv
// DDC byte store: one pre-arbitrated write port,
// async prefetch and host read ports.
module ddc_slv_ram #(
  parameter int AW = 8
) (
  input  logic          ck_ref,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [7:0]    wd,
  input  logic [AW-1:0] pa,
  output logic [7:0]    pd,
  input  logic [AW-1:0] ha,
  output logic [7:0]    hd
);

  localparam int DEPTH = 1 << AW;

  logic [7:0] mem [DEPTH];

  // Contents survive reset, so no reset branch.
  always_ff @(posedge ck_ref) begin
    if (we) mem[wa] <= wd;
  end

  assign pd = mem[pa];
  assign hd = mem[ha];

endmodule

// File: rtl/ddc_slv_regbuf.sv
// DDC/EDID register buffer behind the I2C slave.
// Offset pointer, sequential access, host port.
module ddc_slv_regbuf
  import ddc_slv_pkg::*;
#(
  parameter int         AW      = DDC_AW_DEF,
  parameter logic [7:0] RD_IDLE = DDC_RD_IDLE
) (
  input  logic          ck_ref,
  input  logic          rst_ref,
  input  logic          i2c_start,
  input  logic          i2c_read,
  input  logic          i2c_strobe,
  input  logic [7:0]    i2c_mst_data,
  input  logic          i2c_spc_stop,
  input  logic          r_ddc_wp,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [7:0]    host_wdata,
  output logic [7:0]    i2c_slv_data,
  output logic [7:0]    host_rdata,
  output logic [AW-1:0] ddc_ptr,
  output logic          ddc_upd,
  output logic          ddc_coll
);

  ddc_st_t       st, st_nxt;
  logic [AW-1:0] ptr_nxt;
  logic [AW-1:0] ptr_inc;
  logic [AW-1:0] pf_addr;
  logic          i2c_we;
  logic          ld_slv;
  logic          wr_seen, wr_seen_nxt;
  logic          upd_nxt, coll_nxt;
  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [7:0]    mem_wd;
  logic [7:0]    pf_data;
  logic [7:0]    hr_data;

  assign ptr_inc = ddc_ptr + AW'(1);

  // Host always wins the single write port.
  assign mem_we = host_we | i2c_we;
  assign mem_wa = host_we ? host_addr : ddc_ptr;
  assign mem_wd = host_we ? host_wdata : i2c_mst_data;

  ddc_slv_ram #(.AW(AW)) u_ram (
    .ck_ref (ck_ref),
    .we     (mem_we),
    .wa     (mem_wa),
    .wd     (mem_wd),
    .pa     (pf_addr),
    .pd     (pf_data),
    .ha     (host_addr),
    .hd     (hr_data)
  );

  // Next state, pointer, write request and pulses.
  always_comb begin
    st_nxt      = st;
    ptr_nxt     = ddc_ptr;
    pf_addr     = ddc_ptr;
    i2c_we      = 1'b0;
    ld_slv      = 1'b0;
    wr_seen_nxt = wr_seen;
    upd_nxt     = 1'b0;
    coll_nxt    = 1'b0;
    if (i2c_start) begin
      st_nxt = i2c_read ? ST_RDATA : ST_OFFSET;
      ld_slv = i2c_read;
    end else begin
      if (i2c_strobe) begin
        unique case (st)
          ST_IDLE: ;
          ST_OFFSET: begin
            ptr_nxt = i2c_mst_data[AW-1:0];
            st_nxt  = ST_WDATA;
          end
          ST_WDATA: begin
            ptr_nxt = ptr_inc;
            if (!r_ddc_wp) begin
              if (host_we) begin
                coll_nxt = 1'b1;
              end else begin
                i2c_we      = 1'b1;
                wr_seen_nxt = 1'b1;
              end
            end
          end
          ST_RDATA: begin
            ptr_nxt = ptr_inc;
            pf_addr = ptr_inc;
            ld_slv  = 1'b1;
          end
        endcase
      end
      if (i2c_spc_stop) st_nxt = ST_IDLE;
    end
    // Leaving a write burst reports whether anything landed.
    if (st == ST_WDATA && st_nxt != ST_WDATA) begin
      upd_nxt     = wr_seen_nxt;
      wr_seen_nxt = 1'b0;
    end
  end

  // State, pointer, read data and pulse registers.
  always_ff @(posedge ck_ref or negedge rst_ref) begin
    if (!rst_ref) begin
      st           <= ST_IDLE;
      ddc_ptr      <= '0;
      i2c_slv_data <= RD_IDLE;
      host_rdata   <= 8'h00;
      ddc_upd      <= 1'b0;
      ddc_coll     <= 1'b0;
      wr_seen      <= 1'b0;
    end else begin
      st         <= st_nxt;
      ddc_ptr    <= ptr_nxt;
      host_rdata <= hr_data;
      ddc_upd    <= upd_nxt;
      ddc_coll   <= coll_nxt;
      wr_seen    <= wr_seen_nxt;
      if (ld_slv) i2c_slv_data <= pf_data;
    end
  end

endmodule

// File: tb/tb_ddc_slv_regbuf.sv
// Scoreboard bench for the DDC register buffer.
// Expectations queued at drive time, checked after the edge.
module tb_ddc_slv_regbuf;

  logic       ck_ref = 1'b0;
  logic       rst_ref;
  logic       i2c_start, i2c_read, i2c_strobe, i2c_spc_stop;
  logic [7:0] i2c_mst_data;
  logic       r_ddc_wp, host_we;
  logic [7:0] host_addr, host_wdata;
  logic [7:0] i2c_slv_data, host_rdata, ddc_ptr;
  logic       ddc_upd, ddc_coll;

  always #5 ck_ref = ~ck_ref;

  ddc_slv_regbuf dut (
    .ck_ref       (ck_ref),
    .rst_ref      (rst_ref),
    .i2c_start    (i2c_start),
    .i2c_read     (i2c_read),
    .i2c_strobe   (i2c_strobe),
    .i2c_mst_data (i2c_mst_data),
    .i2c_spc_stop (i2c_spc_stop),
    .r_ddc_wp     (r_ddc_wp),
    .host_we      (host_we),
    .host_addr    (host_addr),
    .host_wdata   (host_wdata),
    .i2c_slv_data (i2c_slv_data),
    .host_rdata   (host_rdata),
    .ddc_ptr      (ddc_ptr),
    .ddc_upd      (ddc_upd),
    .ddc_coll     (ddc_coll)
  );

  typedef enum int {K_SLV, K_HRD, K_PTR, K_UPD, K_COL} kind_t;
  typedef struct {
    kind_t      kind;
    string      tag;
    logic [7:0] exp;
  } sb_t;

  sb_t        sb_q[$];
  logic [7:0] mdl [256];
  int         n_vec = 0;
  int         n_err = 0;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic expect_v(input kind_t k, input string tag,
                          input logic [7:0] v);
    sb_t e;
    e.kind = k;
    e.tag  = tag;
    e.exp  = v;
    sb_q.push_back(e);
  endtask

  task automatic step();
    sb_t e;
    logic [7:0] obs;
    @(posedge ck_ref);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.kind)
        K_SLV:   obs = i2c_slv_data;
        K_HRD:   obs = host_rdata;
        K_PTR:   obs = ddc_ptr;
        K_UPD:   obs = {7'd0, ddc_upd};
        default: obs = {7'd0, ddc_coll};
      endcase
      chk(e.tag, obs, e.exp);
    end
    i2c_start    = 1'b0;
    i2c_strobe   = 1'b0;
    i2c_spc_stop = 1'b0;
    host_we      = 1'b0;
  endtask

  task automatic go_start(input logic rd);
    i2c_start = 1'b1;
    i2c_read  = rd;
  endtask

  task automatic go_strobe(input logic [7:0] d);
    i2c_strobe   = 1'b1;
    i2c_mst_data = d;
  endtask

  task automatic host_rd(input logic [7:0] a, input string tag);
    host_addr = a;
    expect_v(K_HRD, tag, mdl[a]);
    step();
  endtask

  initial begin
    logic [7:0] off;
    logic [7:0] a;
    rst_ref      = 1'b0;
    i2c_start    = 1'b0;
    i2c_read     = 1'b0;
    i2c_strobe   = 1'b0;
    i2c_mst_data = 8'h00;
    i2c_spc_stop = 1'b0;
    r_ddc_wp     = 1'b0;
    host_we      = 1'b0;
    host_addr    = 8'h00;
    host_wdata   = 8'h00;
    #12;
    chk("rst_slv", i2c_slv_data, 8'hFF);
    chk("rst_hrd", host_rdata, 8'h00);
    chk("rst_ptr", ddc_ptr, 8'h00);
    chk("rst_upd", {7'd0, ddc_upd}, 8'h00);
    chk("rst_col", {7'd0, ddc_coll}, 8'h00);
    @(negedge ck_ref);
    rst_ref = 1'b1;

    for (int i = 0; i < 256; i++) begin
      host_we    = 1'b1;
      host_addr  = 8'(i);
      host_wdata = 8'(i);
      mdl[i]     = 8'(i);
      step();
    end

    // Read-before-write on the host port.
    host_we    = 1'b1;
    host_addr  = 8'h30;
    host_wdata = 8'h99;
    expect_v(K_HRD, "rbw_old", 8'h30);
    step();
    mdl[8'h30] = 8'h99;
    host_rd(8'h30, "rbw_new");

    // Sequential read from pointer 0.
    go_start(1'b1);
    expect_v(K_SLV, "rd_start", 8'h00);
    step();
    for (int i = 1; i <= 4; i++) begin
      go_strobe(8'h00);
      expect_v(K_SLV, "rd_seq", 8'(i));
      expect_v(K_PTR, "rd_ptr", 8'(i));
      step();
    end
    i2c_spc_stop = 1'b1;
    expect_v(K_UPD, "rd_noupd", 8'h00);
    step();

    // Offset write burst.
    go_start(1'b0);
    step();
    go_strobe(8'h10);
    expect_v(K_PTR, "wr_off", 8'h10);
    step();
    go_strobe(8'hAA);
    step();
    go_strobe(8'hBB);
    expect_v(K_PTR, "wr_ptr", 8'h12);
    step();
    i2c_spc_stop = 1'b1;
    expect_v(K_UPD, "wr_upd", 8'h01);
    step();
    expect_v(K_UPD, "wr_upd_1cy", 8'h00);
    step();
    mdl[8'h10] = 8'hAA;
    mdl[8'h11] = 8'hBB;
    host_rd(8'h10, "wr_m10");
    host_rd(8'h11, "wr_m11");

    // Pointer wrap on write.
    go_start(1'b0);
    step();
    go_strobe(8'hFF);
    step();
    go_strobe(8'h55);
    expect_v(K_PTR, "wrap_ptr0", 8'h00);
    step();
    go_strobe(8'h66);
    step();
    i2c_spc_stop = 1'b1;
    expect_v(K_PTR, "wrap_ptr1", 8'h01);
    expect_v(K_UPD, "wrap_upd", 8'h01);
    step();
    mdl[8'hFF] = 8'h55;
    mdl[8'h00] = 8'h66;
    host_rd(8'hFF, "wrap_mff");
    host_rd(8'h00, "wrap_m00");

    // Write protect.
    r_ddc_wp = 1'b1;
    go_start(1'b0);
    step();
    go_strobe(8'h20);
    step();
    go_strobe(8'h77);
    step();
    i2c_spc_stop = 1'b1;
    expect_v(K_PTR, "wp_ptr", 8'h21);
    expect_v(K_UPD, "wp_noupd", 8'h00);
    step();
    r_ddc_wp = 1'b0;
    host_rd(8'h20, "wp_m20");

    // Host write collides with I2C byte.
    go_start(1'b0);
    step();
    go_strobe(8'h50);
    step();
    go_strobe(8'hC3);
    host_we    = 1'b1;
    host_addr  = 8'h60;
    host_wdata = 8'hE1;
    expect_v(K_COL, "coll", 8'h01);
    expect_v(K_PTR, "coll_ptr", 8'h51);
    step();
    mdl[8'h60] = 8'hE1;
    i2c_spc_stop = 1'b1;
    expect_v(K_COL, "coll_1cy", 8'h00);
    expect_v(K_UPD, "coll_noupd", 8'h00);
    step();
    host_rd(8'h50, "coll_m50");
    host_rd(8'h60, "coll_m60");

    // Stop with final byte.
    go_start(1'b0);
    step();
    go_strobe(8'h70);
    step();
    go_strobe(8'h12);
    i2c_spc_stop = 1'b1;
    expect_v(K_UPD, "stopsb_upd", 8'h01);
    expect_v(K_PTR, "stopsb_ptr", 8'h71);
    step();
    mdl[8'h70] = 8'h12;
    host_rd(8'h70, "stopsb_m70");

    // Start beats a simultaneous strobe.
    go_start(1'b0);
    step();
    go_start(1'b0);
    go_strobe(8'h33);
    expect_v(K_PTR, "stsb_ptr", 8'h71);
    step();
    go_strobe(8'h80);
    expect_v(K_PTR, "stsb_off", 8'h80);
    step();

    // Random read: offset, Sr, read, then reset mid-read.
    go_start(1'b0);
    expect_v(K_UPD, "sr0_noupd", 8'h00);
    step();
    go_strobe(8'h40);
    step();
    go_start(1'b1);
    expect_v(K_UPD, "sr_noupd", 8'h00);
    expect_v(K_SLV, "sr_slv", mdl[8'h40]);
    step();
    go_strobe(8'h00);
    expect_v(K_SLV, "sr_slv1", mdl[8'h41]);
    expect_v(K_PTR, "sr_ptr1", 8'h41);
    step();
    #2;
    rst_ref = 1'b0;
    #1;
    chk("mrst_slv", i2c_slv_data, 8'hFF);
    chk("mrst_ptr", ddc_ptr, 8'h00);
    @(negedge ck_ref);
    rst_ref = 1'b1;
    go_strobe(8'h5A);
    expect_v(K_PTR, "idle_sb", 8'h00);
    expect_v(K_SLV, "idle_slv", 8'hFF);
    step();
    host_rd(8'h10, "mrst_mem");

    // Random offset reads with wrap.
    for (int k = 0; k < 4; k++) begin
      off = 8'($urandom_range(0, 255));
      if (k == 0) off = 8'hFE;
      go_start(1'b0);
      step();
      go_strobe(off);
      step();
      go_start(1'b1);
      expect_v(K_SLV, "rnd_slv0", mdl[off]);
      step();
      for (int i = 1; i <= 3; i++) begin
        a = off + 8'(i);
        go_strobe(8'h00);
        expect_v(K_SLV, "rnd_slv", mdl[a]);
        expect_v(K_PTR, "rnd_ptr", a);
        step();
      end
      i2c_spc_stop = 1'b1;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
